// File: rtl/seq_complex_mult.sv
// seq_complex_mult: multi-cycle signed complex multiplier, c = a * b.
// It answers the ALU stage's start/ready handshake. One shared WxW signed
// multiplier is used four times: ar*br, ai*bi, ar*bi, ai*br.
// Optional build macro CMUL_SAT_EN: each result component saturates instead
// of wrapping, and a registered `sat` flag output is added.
module seq_complex_mult #(
  parameter int W    = 8,
  parameter int FRAC = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic [2*W-1:0] c,
  output logic           ready
`ifdef CMUL_SAT_EN
  ,
  output logic           sat
`endif
);

  // Accumulator width: one extra bit holds the sum of two full WxW products.
  localparam int AW = 2*W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

`ifdef CMUL_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX_C = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN_C = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  // Scale one accumulator and clamp it to the signed W-bit range.
  function automatic logic [W-1:0] fmt_comp(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    sh = acc >>> FRAC;
    if (sh > SAT_MAX_C) begin
      fmt_comp = W'(SAT_MAX_C);
    end else if (sh < SAT_MIN_C) begin
      fmt_comp = W'(SAT_MIN_C);
    end else begin
      fmt_comp = W'(sh);
    end
  endfunction

  // Report whether the scaled accumulator lies outside the signed W-bit range.
  function automatic logic sat_hit(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    sh = acc >>> FRAC;
    sat_hit = (sh > SAT_MAX_C) || (sh < SAT_MIN_C);
  endfunction
`else
  // Scale one accumulator and keep the low W bits, so large values wrap around.
  function automatic logic [W-1:0] fmt_comp(input logic signed [AW-1:0] acc);
    fmt_comp = W'(acc >>> FRAC);
  endfunction
`endif

  state_t                state_r, state_nxt_s;
  logic [1:0]            step_r, step_nxt_s;
  logic [2*W-1:0]        a_r, a_nxt_s;
  logic [2*W-1:0]        b_r, b_nxt_s;
  logic signed [AW-1:0]  re_acc_r, re_acc_nxt_s;
  logic signed [AW-1:0]  im_acc_r, im_acc_nxt_s;
  logic [2*W-1:0]        c_r, c_nxt_s;
  logic                  sat_r, sat_nxt_s;

  logic signed [W-1:0]   ar_s, ai_s, br_s, bi_s;
  logic signed [W-1:0]   mul_x_s, mul_y_s;
  logic signed [2*W-1:0] prod_s;
  logic signed [AW-1:0]  prod_ext_s;
  logic signed [AW-1:0]  im_sum_s;

  assign ar_s = a_r[2*W-1:W];
  assign ai_s = a_r[W-1:0];
  assign br_s = b_r[2*W-1:W];
  assign bi_s = b_r[W-1:0];

  // Choose the operand pair that the shared multiplier uses in this step.
  always_comb begin
    mul_x_s = ar_s;
    mul_y_s = br_s;
    case (step_r)
      2'd0: begin mul_x_s = ar_s; mul_y_s = br_s; end
      2'd1: begin mul_x_s = ai_s; mul_y_s = bi_s; end
      2'd2: begin mul_x_s = ar_s; mul_y_s = bi_s; end
      2'd3: begin mul_x_s = ai_s; mul_y_s = br_s; end
      default: begin mul_x_s = ar_s; mul_y_s = br_s; end
    endcase
  end

  // The true signed product always fits in 2W bits, and the low 2W bits are
  // the same whatever signedness the sign-extended operands are multiplied with.
  assign prod_s     = {{W{mul_x_s[W-1]}}, mul_x_s} * {{W{mul_y_s[W-1]}}, mul_y_s};
  assign prod_ext_s = {prod_s[2*W-1], prod_s};
  assign im_sum_s   = im_acc_r + prod_ext_s;

  // Compute the next FSM state and the next datapath values.
  always_comb begin
    state_nxt_s  = state_r;
    step_nxt_s   = step_r;
    a_nxt_s      = a_r;
    b_nxt_s      = b_r;
    re_acc_nxt_s = re_acc_r;
    im_acc_nxt_s = im_acc_r;
    c_nxt_s      = c_r;
    sat_nxt_s    = sat_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s  = ST_BUSY;
          step_nxt_s   = 2'd0;
          a_nxt_s      = a;
          b_nxt_s      = b;
          re_acc_nxt_s = {AW{1'b0}};
          im_acc_nxt_s = {AW{1'b0}};
          sat_nxt_s    = 1'b0;
        end else begin
          state_nxt_s  = state_r;
        end
      end
      ST_BUSY: begin
        case (step_r)
          2'd0: begin
            re_acc_nxt_s = re_acc_r + prod_ext_s;
            step_nxt_s   = 2'd1;
          end
          2'd1: begin
            re_acc_nxt_s = re_acc_r - prod_ext_s;
            step_nxt_s   = 2'd2;
          end
          2'd2: begin
            im_acc_nxt_s = im_sum_s;
            step_nxt_s   = 2'd3;
          end
          2'd3: begin
            im_acc_nxt_s = im_sum_s;
            c_nxt_s      = {fmt_comp(re_acc_r), fmt_comp(im_sum_s)};
`ifdef CMUL_SAT_EN
            sat_nxt_s    = sat_hit(re_acc_r) || sat_hit(im_sum_s);
`else
            sat_nxt_s    = 1'b0;
`endif
            step_nxt_s   = 2'd0;
            state_nxt_s  = ST_DONE;
          end
          default: begin
            step_nxt_s   = 2'd0;
            state_nxt_s  = ST_IDLE;
          end
        endcase
      end
      default: begin
        step_nxt_s  = 2'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register. Reset can abort an operation at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: step counter, operand latches, accumulators, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r   <= 2'd0;
      a_r      <= {(2*W){1'b0}};
      b_r      <= {(2*W){1'b0}};
      re_acc_r <= {AW{1'b0}};
      im_acc_r <= {AW{1'b0}};
      c_r      <= {(2*W){1'b0}};
      sat_r    <= 1'b0;
    end else begin
      step_r   <= step_nxt_s;
      a_r      <= a_nxt_s;
      b_r      <= b_nxt_s;
      re_acc_r <= re_acc_nxt_s;
      im_acc_r <= im_acc_nxt_s;
      c_r      <= c_nxt_s;
      sat_r    <= sat_nxt_s;
    end
  end

  // ready is combinational so that it drops in the same cycle start rises.
  assign ready = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && !start;
  assign c     = c_r;

`ifdef CMUL_SAT_EN
  assign sat = sat_r;
`else
  // Without saturation the flag register is held at zero and has no reader.
  logic unused_sat_s;
  assign unused_sat_s = sat_r;
`endif

endmodule
